// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and constants for the 4x4 keypad scan controller.
//   scan_state_t       - FSM encoding of the scan controller.
//   KEY_SUBMIT_LETTER  - key code of R3C0.
//   KEY_SUBMIT_WORD    - key code of R3C2.
//   onehot16_to_code() - converts a one-hot 16-bit scan snapshot to a key code.
package keypad_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } scan_state_t;

  localparam logic [3:0] KEY_SUBMIT_LETTER = 4'hC;
  localparam logic [3:0] KEY_SUBMIT_WORD   = 4'hE;

  // Snapshot bit 4*c+k holds row-line bit k seen while column c was driven.
  // row[3] is R0, so row_idx = 3-k, which for a 2-bit k is simply ~k.
  function automatic logic [3:0] onehot16_to_code(input logic [15:0] snap);
    logic [3:0] code;
    logic [3:0] idx;
    code = 4'h0;
    for (int i = 0; i < 16; i++) begin
      idx = 4'(i);
      if (snap[i]) code = {~idx[1:0], idx[3:2]};
    end
    return code;
  endfunction

endpackage

// File: rtl/keypad_scan_ctrl_sync2.sv
// keypad_scan_ctrl_sync2: 2-FF synchronizer, 4 bits wide, synchronous active-low
// reset to zero.
//   clk   in  system clock
//   nRst  in  synchronous active-low reset
//   d     in  4-bit asynchronous input
//   q     out 4-bit synchronized output
module sync2 (
  input  logic       clk,
  input  logic       nRst,
  input  logic [3:0] d,
  output logic [3:0] q
);

  logic [3:0] meta_q;
  logic [3:0] sync_q;

  always_ff @(posedge clk) begin
    if (!nRst) begin
      meta_q <= 4'b0;
      sync_q <= 4'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: scan controller for one 4x4 keypad. Drives one-hot columns,
// samples synchronized rows at the end of each column dwell, debounces whole
// scans, rejects multi-key presses and requires a full release between keys.
//   clk        in  system clock
//   nRst       in  synchronous active-low reset
//   row[3:0]   in  raw rows, active-high, async (row[3]=R0 .. row[0]=R3)
//   col[3:0]   out one-hot column drive (col[0]=C0 .. col[3]=C3)
//   key_code   out {row_idx, col_idx} of the last accepted key, held
//   key_valid  out one-cycle strobe per accepted key
//   key_held   out high while the accepted key is still down
//   multi_err  out one-cycle strobe when an idle scan sees several keys
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 12000,
  parameter int DEBOUNCE_SCANS = 8
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held,
  output logic       multi_err
);

  localparam int         DW       = $clog2(SCAN_DIV);
  localparam logic [7:0] DB_LIMIT = 8'(DEBOUNCE_SCANS);

  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  logic [3:0]    rows_sync;

  logic [DW-1:0] dwell_q, dwell_d;
  logic [1:0]    col_idx_q, col_idx_d;
  logic [15:0]   snapshot_q, snapshot_d;
  scan_state_t   state_q, state_d;
  logic [15:0]   cand_q, cand_d;
  logic [7:0]    stable_cnt_q, stable_cnt_d;
  logic [7:0]    release_cnt_q, release_cnt_d;
  logic [3:0]    key_code_q, key_code_d;
  logic          key_valid_q, key_valid_d;
  logic          multi_err_q, multi_err_d;

  logic          dwell_last;
  logic          scan_eval;
  logic [15:0]   snap_full;
  logic          snap_any;
  logic          snap_multi;
  logic          snap_one;

  sync2 u_sync2 (
    .clk  (clk),
    .nRst (nRst),
    .d    (row),
    .q    (rows_sync)
  );

  assign dwell_last = (dwell_q == DW'(SCAN_DIV - 1));
  assign scan_eval  = dwell_last && (col_idx_q == 2'd3);

  // The column-3 nibble is still being captured on the evaluation cycle, so
  // the evaluated snapshot takes it straight from the synchronizer.
  assign snap_full  = {rows_sync, snapshot_q[11:0]};
  assign snap_any   = (snap_full != 16'h0);
  assign snap_multi = ((snap_full & (snap_full - 16'd1)) != 16'h0);
  assign snap_one   = snap_any && !snap_multi;

  // Dwell counter, column index and snapshot capture
  always_comb begin
    dwell_d    = dwell_q + DW'(1);
    col_idx_d  = col_idx_q;
    snapshot_d = snapshot_q;
    if (dwell_last) begin
      dwell_d    = '0;
      col_idx_d  = col_idx_q + 2'd1;
      snapshot_d[{col_idx_q, 2'b00} +: 4] = rows_sync;
    end
  end

  // Scan-level FSM, evaluated once per full scan
  always_comb begin
    state_d       = state_q;
    cand_d        = cand_q;
    stable_cnt_d  = stable_cnt_q;
    release_cnt_d = release_cnt_q;
    key_code_d    = key_code_q;
    key_valid_d   = 1'b0;
    multi_err_d   = 1'b0;
    if (scan_eval) begin
      case (state_q)
        IDLE: begin
          if (snap_one) begin
            cand_d       = snap_full;
            stable_cnt_d = 8'd1;
            if (DB_LIMIT <= 8'd1) begin
              key_code_d  = onehot16_to_code(snap_full);
              key_valid_d = 1'b1;
              state_d     = PRESSED;
            end else begin
              state_d = DEBOUNCE;
            end
          end else if (snap_multi) begin
            multi_err_d   = 1'b1;
            release_cnt_d = 8'd0;
            state_d       = RELEASE;
          end
        end
        DEBOUNCE: begin
          if (snap_full == cand_q) begin
            stable_cnt_d = sat_inc(stable_cnt_q);
            if (stable_cnt_d >= DB_LIMIT) begin
              key_code_d  = onehot16_to_code(cand_q);
              key_valid_d = 1'b1;
              state_d     = PRESSED;
            end
          end else begin
            stable_cnt_d = 8'd0;
            state_d      = IDLE;
          end
        end
        PRESSED: begin
          if (!snap_any) begin
            release_cnt_d = 8'd1;
            state_d       = RELEASE;
          end
        end
        RELEASE: begin
          // Any key seen restarts the release count; a new key is only
          // accepted after a full quiet period.
          if (!snap_any) begin
            release_cnt_d = sat_inc(release_cnt_q);
            if (release_cnt_d >= DB_LIMIT) begin
              release_cnt_d = 8'd0;
              stable_cnt_d  = 8'd0;
              state_d       = IDLE;
            end
          end else begin
            release_cnt_d = 8'd0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!nRst) begin
      dwell_q       <= '0;
      col_idx_q     <= 2'd0;
      snapshot_q    <= 16'h0;
      state_q       <= IDLE;
      cand_q        <= 16'h0;
      stable_cnt_q  <= 8'd0;
      release_cnt_q <= 8'd0;
      key_code_q    <= 4'h0;
      key_valid_q   <= 1'b0;
      multi_err_q   <= 1'b0;
    end else begin
      dwell_q       <= dwell_d;
      col_idx_q     <= col_idx_d;
      snapshot_q    <= snapshot_d;
      state_q       <= state_d;
      cand_q        <= cand_d;
      stable_cnt_q  <= stable_cnt_d;
      release_cnt_q <= release_cnt_d;
      key_code_q    <= key_code_d;
      key_valid_q   <= key_valid_d;
      multi_err_q   <= multi_err_d;
    end
  end

  assign col       = 4'(4'b0001 << col_idx_q);
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = (state_q == PRESSED);
  assign multi_err = multi_err_q;

endmodule
